// File: rtl/scomp_memory_responder.sv
// Memory-side responder for the SCOMP core: 256x16 RAM, a 4-word I/O window
// (switches, LEDs, timer) and a boot loader that holds the CPU in reset while loading.
module scomp_memory_responder #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE    = 8'hFC,
    parameter int                    TIMER_DIV  = 1000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  we,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  cpu_hold,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    input  logic [7:0]            switches,
    output logic [DATA_WIDTH-1:0] leds
);

    localparam int                DEPTH   = 2 ** ADDR_WIDTH;
    localparam int                PW      = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [PW-1:0]     PRE_MAX = PW'(TIMER_DIV - 1);

    typedef enum logic {
        LOAD,
        RUN
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   load_ptr_q, load_ptr_d;
    logic                    load_accept;
    logic                    cpu_wr;
    logic [ADDR_WIDTH-1:0]   io_off;
    logic                    io_hit;
    logic [DATA_WIDTH-1:0]   ram [0:DEPTH-1];
    logic [DATA_WIDTH-1:0]   timer_q;
    logic [PW-1:0]           prescaler_q;
    logic [7:0]              sw_sync_p0, sw_sync_p1;

    assign io_off     = address - IO_BASE;
    assign io_hit     = (address >= IO_BASE) && (io_off < ADDR_WIDTH'(4));
    assign cpu_wr     = (state_q == RUN) && we;
    assign cpu_hold   = (state_q == LOAD);
    assign load_ready = (state_q == LOAD);

    // Loader pointer saturates at the top address; the last slot always ends the load.
    always_comb begin
        state_d     = state_q;
        load_ptr_d  = load_ptr_q;
        load_accept = 1'b0;
        case (state_q)
            LOAD: begin
                if (load_start) begin
                    load_ptr_d = '0;
                end else if (load_valid) begin
                    load_accept = 1'b1;
                    if (load_ptr_q != '1)
                        load_ptr_d = load_ptr_q + ADDR_WIDTH'(1);
                    if (load_last || (load_ptr_q == '1))
                        state_d = RUN;
                end
            end
            RUN: begin
                if (load_start) begin
                    state_d    = LOAD;
                    load_ptr_d = '0;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= LOAD;
            load_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            load_ptr_q <= load_ptr_d;
        end
    end

    // RAM is never reset; the CPU cannot reach cells hidden under the I/O window.
    always_ff @(posedge clock) begin
        if (load_accept)
            ram[load_ptr_q] <= load_data;
        else if (cpu_wr && !io_hit)
            ram[address] <= data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            leds        <= '0;
            timer_q     <= '0;
            prescaler_q <= '0;
            sw_sync_p0  <= '0;
            sw_sync_p1  <= '0;
        end else begin
            sw_sync_p0 <= switches;
            sw_sync_p1 <= sw_sync_p0;
            if (cpu_wr && io_hit && (io_off[1:0] == 2'd1))
                leds <= data;
            // A CPU timer write takes priority over a same-cycle prescaler wrap.
            if (cpu_wr && io_hit && (io_off[1:0] == 2'd2)) begin
                timer_q     <= data;
                prescaler_q <= '0;
            end else if (prescaler_q == PRE_MAX) begin
                prescaler_q <= '0;
                timer_q     <= timer_q + DATA_WIDTH'(1);
            end else begin
                prescaler_q <= prescaler_q + PW'(1);
            end
        end
    end

    always_comb begin
        q = ram[address];
        if (io_hit) begin
            case (io_off[1:0])
                2'd0:    q = DATA_WIDTH'(sw_sync_p1);
                2'd1:    q = leds;
                2'd2:    q = timer_q;
                default: q = '0;
            endcase
        end
    end

endmodule
